// File: rtl/cmplx_mac_pipe.sv
// Three-stage signed complex multiply (optionally by conj(b)) with optional saturating
// frame accumulation: operands -> four partial products -> combine/accumulate -> output.
module cmplx_mac_pipe #(
   parameter int DW     = 18,
   parameter int ACCW   = 40,
   parameter int ACC_EN = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic                   conj_b,
   input  logic signed [DW-1:0]   real_a,
   input  logic signed [DW-1:0]   imag_a,
   input  logic signed [DW-1:0]   real_b,
   input  logic signed [DW-1:0]   imag_b,
   output logic                   out_valid,
   output logic signed [ACCW-1:0] real_out,
   output logic signed [ACCW-1:0] imag_out,
   output logic                   sat
);

   localparam int PW  = 2 * DW;
   localparam int EXT = ACCW - PW;
   localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

   // stage 1: operands and per-sample controls (frame flags pre-qualified by valid)
   logic                 r_v1, r_first1, r_last1, r_conj1;
   logic signed [DW-1:0] r_ar, r_ai, r_br, r_bi;

   // stage 2: partial products
   logic                 r_v2, r_first2, r_last2, r_conj2;
   logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;

   // stage 3: accumulator, sticky frame clamp, output registers
   logic signed [ACCW-1:0] r_acc_re, r_acc_im;
   logic                   r_sat_acc;
   logic                   r_out_v;
   logic signed [ACCW-1:0] r_out_re, r_out_im;
   logic                   r_out_sat;

   logic signed [ACCW-1:0] w_rr, w_ii, w_ri, w_ir;
   logic signed [ACCW-1:0] w_re, w_im;
   logic signed [ACCW-1:0] w_base_re, w_base_im;
   logic signed [ACCW:0]   w_sum_re, w_sum_im;
   logic                   w_clip_re, w_clip_im;
   logic signed [ACCW-1:0] w_acc_re, w_acc_im;
   logic                   w_sat_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_first1 <= 1'b0;
         r_last1  <= 1'b0;
         r_conj1  <= 1'b0;
         r_ar     <= '0;
         r_ai     <= '0;
         r_br     <= '0;
         r_bi     <= '0;
      end else begin
         r_v1     <= in_valid;
         r_first1 <= in_valid & in_first;
         r_last1  <= in_valid & in_last;
         r_conj1  <= conj_b;
         r_ar     <= real_a;
         r_ai     <= imag_a;
         r_br     <= real_b;
         r_bi     <= imag_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2     <= 1'b0;
         r_first2 <= 1'b0;
         r_last2  <= 1'b0;
         r_conj2  <= 1'b0;
         r_p_rr   <= '0;
         r_p_ii   <= '0;
         r_p_ri   <= '0;
         r_p_ir   <= '0;
      end else begin
         r_v2     <= r_v1;
         r_first2 <= r_first1;
         r_last2  <= r_last1;
         r_conj2  <= r_conj1;
         r_p_rr   <= r_ar * r_br;
         r_p_ii   <= r_ai * r_bi;
         r_p_ri   <= r_ar * r_bi;
         r_p_ir   <= r_ai * r_br;
      end
   end

   // ACCW >= 2*DW+1, so combining two products here can never overflow
   always_comb begin
      w_rr = {{EXT{r_p_rr[PW-1]}}, r_p_rr};
      w_ii = {{EXT{r_p_ii[PW-1]}}, r_p_ii};
      w_ri = {{EXT{r_p_ri[PW-1]}}, r_p_ri};
      w_ir = {{EXT{r_p_ir[PW-1]}}, r_p_ir};
      if (r_conj2) begin
         w_re = w_rr + w_ii;
         w_im = w_ir - w_ri;
      end else begin
         w_re = w_rr - w_ii;
         w_im = w_ri + w_ir;
      end
   end

   // one extra sum bit exposes overflow; a clamped acc keeps accumulating from the rail
   always_comb begin
      w_base_re  = r_first2 ? '0 : r_acc_re;
      w_base_im  = r_first2 ? '0 : r_acc_im;
      w_sum_re   = {w_base_re[ACCW-1], w_base_re} + {w_re[ACCW-1], w_re};
      w_sum_im   = {w_base_im[ACCW-1], w_base_im} + {w_im[ACCW-1], w_im};
      w_clip_re  = w_sum_re[ACCW] ^ w_sum_re[ACCW-1];
      w_clip_im  = w_sum_im[ACCW] ^ w_sum_im[ACCW-1];
      w_acc_re   = w_sum_re[ACCW-1:0];
      w_acc_im   = w_sum_im[ACCW-1:0];
      if (w_clip_re) w_acc_re = w_sum_re[ACCW] ? ACC_MIN : ACC_MAX;
      if (w_clip_im) w_acc_im = w_sum_im[ACCW] ? ACC_MIN : ACC_MAX;
      w_sat_next = (r_first2 ? 1'b0 : r_sat_acc) | w_clip_re | w_clip_im;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_re  <= '0;
         r_acc_im  <= '0;
         r_sat_acc <= 1'b0;
         r_out_v   <= 1'b0;
         r_out_re  <= '0;
         r_out_im  <= '0;
         r_out_sat <= 1'b0;
      end else begin
         if (r_v2) begin
            r_acc_re  <= w_acc_re;
            r_acc_im  <= w_acc_im;
            r_sat_acc <= w_sat_next;
         end
         if (ACC_EN != 0) begin
            r_out_v <= r_v2 & r_last2;
            if (r_v2 && r_last2) begin
               r_out_re  <= w_acc_re;
               r_out_im  <= w_acc_im;
               r_out_sat <= w_sat_next;
            end
         end else begin
            r_out_v <= r_v2;
            if (r_v2) begin
               r_out_re  <= w_re;
               r_out_im  <= w_im;
               r_out_sat <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_out_v;
   assign real_out  = r_out_re;
   assign imag_out  = r_out_im;
   assign sat       = r_out_sat;

endmodule
